fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding a single sync FIFO.
// A grant is held for up to MAX_BURST writes or until the owner drops its request.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int D_WIDTH   = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  input  logic                       full,
  output logic [N_REQ-1:0]           gnt,
  output logic                       wr,
  output logic [D_WIDTH-1:0]         w_data,
  output logic [2:0]                 owner,
  output logic                       busy,
  output logic [15:0]                stall_cnt
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [2:0]    LAST_RST   = 3'(N_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      last_owner_q, last_owner_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic            owner_req;
  logic            release_now;
  logic [2:0]      ptr;
  logic [2:0]      win_hi, win_lo, winner;
  logic            found_hi, found_lo;

  always_comb begin
    busy      = (state_q == BUSY);
    owner_req = 1'b0;
    gnt       = '0;
    w_data    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == 3'(i)) owner_req = req[i];
      if (busy && (owner_q == 3'(i)) && req[i] && !full) begin
        gnt[i] = 1'b1;
        w_data = req_data[i*D_WIDTH +: D_WIDTH];
      end
    end
    wr = |gnt;
  end

  assign owner     = owner_q;
  assign stall_cnt = stall_cnt_q;

  // Rotating priority as two passes: indices above the pointer first, then the wrap.
  // While busy the pointer is the owner itself, since a release reloads last_owner with it.
  always_comb begin
    ptr      = busy ? owner_q : last_owner_q;
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found_hi && req[i] && (3'(i) > ptr)) begin
        found_hi = 1'b1;
        win_hi   = 3'(i);
      end
      if (!found_lo && req[i] && (3'(i) <= ptr)) begin
        found_lo = 1'b1;
        win_lo   = 3'(i);
      end
    end
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    release_now  = busy && (!owner_req || (wr && (burst_cnt_q == BURST_LAST)));

    if (busy && owner_req && full && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d     = winner;
          burst_cnt_d = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          last_owner_d = owner_q;
          burst_cnt_d  = '0;
          if (|req) owner_d = winner;
          else      state_d = IDLE;
        end else if (wr) begin
          burst_cnt_d = burst_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      burst_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed checks of fifo_wr_arbiter against a grant/burst reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            full;
  logic [N-1:0]    gnt;
  logic            wr;
  logic [DW-1:0]   w_data;
  logic [2:0]      owner;
  logic            busy;
  logic [15:0]     stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int m_busy, m_owner, m_last, m_writes, m_stall;

  fifo_wr_arbiter #(.N_REQ(N), .D_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt), .wr(wr), .w_data(w_data), .owner(owner), .busy(busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int req_bit(input int i);
    return (int'(req) >> i) & 1;
  endfunction

  function automatic int rr_pick(input int p);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (req_bit(c) == 1) return c;
    end
    return p;
  endfunction

  function automatic int exp_gnt();
    if (m_busy == 1 && req_bit(m_owner) == 1 && full == 1'b0) return 1 << m_owner;
    return 0;
  endfunction

  function automatic int exp_wdata();
    if (exp_gnt() != 0) return (int'(req_data) >> (DW * m_owner)) & 8'hFF;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_writes = 0; m_stall = 0;
  endtask

  // Called right after a posedge, while the inputs of the elapsed cycle are still applied.
  task automatic model_step();
    int wrote;
    wrote = (exp_gnt() != 0) ? 1 : 0;
    if (m_busy == 1 && req_bit(m_owner) == 1 && full == 1'b1 && m_stall < 65535) m_stall++;
    if (m_busy == 0) begin
      if (req != 0) begin
        m_owner = rr_pick(m_last); m_writes = 0; m_busy = 1;
      end
    end else if (req_bit(m_owner) == 0 || (m_writes + wrote) == MB) begin
      m_last = m_owner; m_writes = 0;
      if (req != 0) m_owner = rr_pick(m_last);
      else          m_busy  = 0;
    end else begin
      m_writes += wrote;
    end
  endtask

  task automatic check_outputs();
    check("gnt",       32'(gnt),       exp_gnt());
    check("wr",        32'(wr),        (exp_gnt() != 0) ? 1 : 0);
    check("w_data",    32'(w_data),    exp_wdata());
    check("owner",     32'(owner),     m_owner);
    check("busy",      32'(busy),      m_busy);
    check("stall_cnt", 32'(stall_cnt), m_stall);
  endtask

  // Entered at posedge+1; drives inputs, checks near the negedge, steps the model.
  task automatic cycle(input logic [N-1:0] r, input logic f);
    req      = r;
    full     = f;
    req_data = $urandom;
    #4;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic reset_mid_cycle();
    #2;
    reset = 1'b1;
    #1;
    check("rst_wr",    32'(wr),        0);
    check("rst_gnt",   32'(gnt),       0);
    check("rst_busy",  32'(busy),      0);
    check("rst_wdata", 32'(w_data),    0);
    check("rst_stall", 32'(stall_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] r;
    reset = 1'b1; req = '0; full = 1'b0; req_data = '0;
    model_reset();
    #1;
    check_outputs();
    check("rst_owner", 32'(owner), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // single requester, then idle
    for (int i = 0; i < 4; i++) cycle(4'b0010, 1'b0);
    check("single_owner", 32'(owner), 1);
    for (int i = 0; i < 2; i++) cycle(4'b0000, 1'b0);

    // burst alternation between two requesters
    for (int i = 0; i < 14; i++) cycle(4'b0011, 1'b0);
    for (int i = 0; i < 2; i++) cycle(4'b0000, 1'b0);

    // all four requesters held
    for (int i = 0; i < 12; i++) cycle(4'b1111, 1'b0);
    cycle(4'b0000, 1'b0);

    // full stall mid-burst for owner 2
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0100, 1'b1);
    check("stall3", 32'(stall_cnt), 3);
    for (int i = 0; i < 3; i++) cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);

    // owner 0 drops after two writes while requester 3 waits
    cycle(4'b0001, 1'b0);
    cycle(4'b1001, 1'b0);
    cycle(4'b1001, 1'b0);
    cycle(4'b1000, 1'b0);
    check("drop_owner", 32'(owner), 3);
    cycle(4'b1000, 1'b1);
    cycle(4'b0000, 1'b0);

    // reset during an owner-1 burst
    for (int i = 0; i < 3; i++) cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b1);
    req = 4'b0010; full = 1'b0;
    reset_mid_cycle();
    cycle(4'b1111, 1'b0);
    check("post_rst_owner", 32'(owner), 0);
    for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b0);

    // random traffic
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      if ($urandom_range(299) == 0) begin
        req = r; full = 1'b0;
        reset_mid_cycle();
      end
      cycle(r, ($urandom_range(3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
